top_control_s_axi: RTL and testbench

AXI4-Lite slave control register file that sits directly upstream of the kernel top. It lets the host program the two 64-bit buffer pointers (axi00_ptr0/axi00_ptr1) and start the kernel. It produces the level ap_start and observes the kernel's ap_idle and ap_done. It also holds sticky done status for host polling.

---
 rtl/top_control_s_axi.sv | 232 +++++++++++++++++++++++
 tb/tb_top_control_s_axi.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_control_s_axi.sv
// top_control_s_axi: AXI4-Lite control register file for the kernel top.
// Holds the two 64-bit buffer pointers, the ap_start level and the sticky
// ap_done status, and reports the live ap_idle level.
// Optional build macro CTRL_IRQ_EN adds GIE/IER/ISR and the interrupt output.
// Without the macro those registers read 0 and ignore writes.
// Map (byte address, low two bits ignored; 0x20 and above unmapped):
//   0x00 CTRL  bit0 ap_start (write-1-set), bit1 ap_done (sticky, clear-on-read),
//              bit2 ap_idle (live)
//   0x04 GIE   0x08 IER   0x0C ISR (toggle-on-write-1)
//   0x10/0x14 ptr0 low/high   0x18/0x1C ptr1 low/high
module top_control_s_axi #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          s_axi_control_awvalid,
  output logic                          s_axi_control_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_control_awaddr,
  input  logic                          s_axi_control_wvalid,
  output logic                          s_axi_control_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_control_wdata,
  input  logic [3:0]                    s_axi_control_wstrb,
  output logic                          s_axi_control_bvalid,
  input  logic                          s_axi_control_bready,
  output logic [1:0]                    s_axi_control_bresp,
  input  logic                          s_axi_control_arvalid,
  output logic                          s_axi_control_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_control_araddr,
  output logic                          s_axi_control_rvalid,
  input  logic                          s_axi_control_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_control_rdata,
  output logic [1:0]                    s_axi_control_rresp,
  output logic                          ap_start,
  input  logic                          ap_idle,
  input  logic                          ap_done,
  output logic [63:0]                   axi00_ptr0,
  output logic [63:0]                   axi00_ptr1
`ifdef CTRL_IRQ_EN
  ,
  output logic                          interrupt
`endif
);

  localparam int WW = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [WW-1:0] A_CTRL  = WW'(0);
  localparam logic [WW-1:0] A_GIE   = WW'(1);
  localparam logic [WW-1:0] A_IER   = WW'(2);
  localparam logic [WW-1:0] A_ISR   = WW'(3);
  localparam logic [WW-1:0] A_P0_LO = WW'(4);
  localparam logic [WW-1:0] A_P0_HI = WW'(5);
  localparam logic [WW-1:0] A_P1_LO = WW'(6);
  localparam logic [WW-1:0] A_P1_HI = WW'(7);

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_t;
  typedef enum logic       {RDIDLE, RDDATA}         rstate_t;

  wstate_t       wstate, wnext;
  rstate_t       rstate, rnext;
  logic [WW-1:0] wword;
  logic [WW-1:0] rword;
  logic          wr_fire;
  logic          rd_fire;
  logic [31:0]   wmask;
  logic [31:0]   rmux;
  logic          start_q;
  logic          done_q;
  logic          start_set;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0]};

  assign wr_fire   = (wstate == WRDATA) && s_axi_control_wvalid;
  assign rd_fire   = (rstate == RDIDLE) && s_axi_control_arvalid;
  assign rword     = s_axi_control_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wmask     = {{8{s_axi_control_wstrb[3]}}, {8{s_axi_control_wstrb[2]}},
                      {8{s_axi_control_wstrb[1]}}, {8{s_axi_control_wstrb[0]}}};
  assign start_set = wr_fire && (wword == A_CTRL) && s_axi_control_wstrb[0]
                     && s_axi_control_wdata[0];

  assign s_axi_control_bresp = 2'b00;
  assign s_axi_control_rresp = 2'b00;
  assign ap_start            = start_q;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Write FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) wstate <= WRIDLE;
    else           wstate <= wnext;
  end

  // Write FSM next state
  always_comb begin
    wnext = wstate;
    case (wstate)
      WRIDLE:  if (s_axi_control_awvalid) wnext = WRDATA;
      WRDATA:  if (s_axi_control_wvalid)  wnext = WRRESP;
      WRRESP:  if (s_axi_control_bready)  wnext = WRIDLE;
      default: wnext = WRIDLE;
    endcase
  end

  // Write FSM handshake outputs
  always_comb begin
    s_axi_control_awready = 1'b0;
    s_axi_control_wready  = 1'b0;
    s_axi_control_bvalid  = 1'b0;
    case (wstate)
      WRIDLE:  s_axi_control_awready = 1'b1;
      WRDATA:  s_axi_control_wready  = 1'b1;
      WRRESP:  s_axi_control_bvalid  = 1'b1;
      default: ;
    endcase
  end

  // Latch the write word address on the AW handshake
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) wword <= '0;
    else if ((wstate == WRIDLE) && s_axi_control_awvalid)
      wword <= s_axi_control_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  end

  // Read FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rstate <= RDIDLE;
    else           rstate <= rnext;
  end

  // Read FSM next state
  always_comb begin
    rnext = rstate;
    case (rstate)
      RDIDLE:  if (s_axi_control_arvalid) rnext = RDDATA;
      RDDATA:  if (s_axi_control_rready)  rnext = RDIDLE;
      default: rnext = RDIDLE;
    endcase
  end

  // Read FSM handshake outputs
  always_comb begin
    s_axi_control_arready = (rstate == RDIDLE);
    s_axi_control_rvalid  = (rstate == RDDATA);
  end

  // Buffer pointers, byte-masked writes, accepted at any time
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      axi00_ptr0 <= '0;
      axi00_ptr1 <= '0;
    end else if (wr_fire) begin
      case (wword)
        A_P0_LO: axi00_ptr0[31:0]  <= merge(axi00_ptr0[31:0],  s_axi_control_wdata, wmask);
        A_P0_HI: axi00_ptr0[63:32] <= merge(axi00_ptr0[63:32], s_axi_control_wdata, wmask);
        A_P1_LO: axi00_ptr1[31:0]  <= merge(axi00_ptr1[31:0],  s_axi_control_wdata, wmask);
        A_P1_HI: axi00_ptr1[63:32] <= merge(axi00_ptr1[63:32], s_axi_control_wdata, wmask);
        default: ;
      endcase
    end
  end

  // ap_start: a set-write beats a same-cycle ap_done
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)     start_q <= 1'b0;
    else if (start_set) start_q <= 1'b1;
    else if (ap_done)   start_q <= 1'b0;
  end

  // Sticky done: a new ap_done beats the clear from a CTRL read
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                         done_q <= 1'b0;
    else if (ap_done)                      done_q <= 1'b1;
    else if (rd_fire && (rword == A_CTRL)) done_q <= 1'b0;
  end

`ifdef CTRL_IRQ_EN
  logic gie_q;
  logic ier_q;
  logic isr_q;
  logic irq_q;

  assign interrupt = irq_q;

  // Interrupt enables and status; ap_done capture beats a toggle-write
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      gie_q <= 1'b0;
      ier_q <= 1'b0;
      isr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_fire && (wword == A_GIE) && s_axi_control_wstrb[0]) gie_q <= s_axi_control_wdata[0];
      if (wr_fire && (wword == A_IER) && s_axi_control_wstrb[0]) ier_q <= s_axi_control_wdata[0];
      if (ier_q && ap_done)
        isr_q <= 1'b1;
      else if (wr_fire && (wword == A_ISR) && s_axi_control_wstrb[0] && s_axi_control_wdata[0])
        isr_q <= ~isr_q;
      irq_q <= gie_q & isr_q;
    end
  end
`endif

  // Read data multiplexer
  always_comb begin
    rmux = '0;
    case (rword)
      A_CTRL:  rmux = {29'd0, ap_idle, done_q, start_q};
`ifdef CTRL_IRQ_EN
      A_GIE:   rmux = {31'd0, gie_q};
      A_IER:   rmux = {31'd0, ier_q};
      A_ISR:   rmux = {31'd0, isr_q};
`endif
      A_P0_LO: rmux = axi00_ptr0[31:0];
      A_P0_HI: rmux = axi00_ptr0[63:32];
      A_P1_LO: rmux = axi00_ptr1[31:0];
      A_P1_HI: rmux = axi00_ptr1[63:32];
      default: rmux = '0;
    endcase
  end

  // Registered read data, captured on the AR handshake and held until rready
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)    s_axi_control_rdata <= '0;
    else if (rd_fire) s_axi_control_rdata <= rmux;
  end

endmodule

// File: tb/tb_top_control_s_axi.sv
// tb_top_control_s_axi: directed, table-driven bench for top_control_s_axi.
module tb_top_control_s_axi;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [5:0]  awaddr = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [5:0]  araddr = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        ap_start;
  logic        ap_idle = 1'b1;
  logic        ap_done = 1'b0;
  logic [63:0] ptr0;
  logic [63:0] ptr1;
`ifdef CTRL_IRQ_EN
  logic        interrupt;
  localparam logic [31:0] GIE_RB = 32'h1;
`else
  localparam logic [31:0] GIE_RB = 32'h0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  top_control_s_axi #(
    .C_S_AXI_ADDR_WIDTH(6),
    .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .s_axi_control_awvalid (awvalid),
    .s_axi_control_awready (awready),
    .s_axi_control_awaddr  (awaddr),
    .s_axi_control_wvalid  (wvalid),
    .s_axi_control_wready  (wready),
    .s_axi_control_wdata   (wdata),
    .s_axi_control_wstrb   (wstrb),
    .s_axi_control_bvalid  (bvalid),
    .s_axi_control_bready  (bready),
    .s_axi_control_bresp   (bresp),
    .s_axi_control_arvalid (arvalid),
    .s_axi_control_arready (arready),
    .s_axi_control_araddr  (araddr),
    .s_axi_control_rvalid  (rvalid),
    .s_axi_control_rready  (rready),
    .s_axi_control_rdata   (rdata),
    .s_axi_control_rresp   (rresp),
    .ap_start              (ap_start),
    .ap_idle               (ap_idle),
    .ap_done               (ap_done),
    .axi00_ptr0            (ptr0),
    .axi00_ptr1            (ptr1)
`ifdef CTRL_IRQ_EN
    ,
    .interrupt             (interrupt)
`endif
  );

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_start;
    logic [63:0] exp_p0;
    logic [63:0] exp_p1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [5:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] exp_rd,
                              input logic exp_start, input logic [63:0] p0, input logic [63:0] p1);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_rd = exp_rd; v.exp_start = exp_start; v.exp_p0 = p0; v.exp_p1 = p1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s: handshake never seen, expected within 20 cycles", name);
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic pulse_done);
    int unsigned n;
    awaddr = a; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    if (!awready) timeout("awready");
    tick();
    awvalid = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 20) begin tick(); n++; end
    if (!wready) timeout("wready");
    if (pulse_done) ap_done = 1'b1;
    tick();
    wvalid = 1'b0; ap_done = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (!bvalid) timeout("bvalid");
    check("bresp", 64'(bresp), 64'h0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, input logic pulse_done, output logic [31:0] d);
    int unsigned n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    if (!arready) timeout("arready");
    if (pulse_done) ap_done = 1'b1;
    tick();
    arvalid = 1'b0; ap_done = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (!rvalid) timeout("rvalid");
    d = rdata;
    check("rresp", 64'(rresp), 64'h0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic pulse_done;
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [63:0] p0;
    logic [63:0] p1;

    p0 = 64'h0000FF01_DEADBEEF;
    p1 = 64'h00000000_AA345678;

    // Reads of the whole map after reset, then pointer writes and readback
    vecs.push_back(mk(0, 6'h00, 0, 0, 32'h4, 0, 0, 0));
    vecs.push_back(mk(0, 6'h04, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 6'h08, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 6'h0C, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 6'h10, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 6'h14, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 6'h18, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 6'h1F, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 6'h10, 32'hDEADBEEF, 4'hF, 0, 0, 64'h0_DEADBEEF, 0));
    vecs.push_back(mk(1, 6'h14, 32'h00000001, 4'hF, 0, 0, 64'h1_DEADBEEF, 0));
    vecs.push_back(mk(1, 6'h18, 32'h12345678, 4'hF, 0, 0, 64'h1_DEADBEEF, 64'h12345678));
    vecs.push_back(mk(1, 6'h1C, 32'h00000000, 4'hF, 0, 0, 64'h1_DEADBEEF, 64'h12345678));
    vecs.push_back(mk(1, 6'h16, 32'hFFFFFFFF, 4'b0010, 0, 0, p0, 64'h12345678));
    vecs.push_back(mk(1, 6'h18, 32'hAA000000, 4'b1000, 0, 0, p0, p1));
    vecs.push_back(mk(0, 6'h10, 0, 0, 32'hDEADBEEF, 0, p0, p1));
    vecs.push_back(mk(0, 6'h15, 0, 0, 32'h0000FF01, 0, p0, p1));
    vecs.push_back(mk(0, 6'h18, 0, 0, 32'hAA345678, 0, p0, p1));
    vecs.push_back(mk(0, 6'h1C, 0, 0, 32'h00000000, 0, p0, p1));
    vecs.push_back(mk(1, 6'h30, 32'hFFFFFFFF, 4'hF, 0, 0, p0, p1));
    vecs.push_back(mk(1, 6'h38, 32'h55555555, 4'hF, 0, 0, p0, p1));
    vecs.push_back(mk(0, 6'h30, 0, 0, 32'h0, 0, p0, p1));
    vecs.push_back(mk(1, 6'h04, 32'h00000001, 4'hF, 0, 0, p0, p1));
    vecs.push_back(mk(0, 6'h04, 0, 0, GIE_RB, 0, p0, p1));
    vecs.push_back(mk(1, 6'h00, 32'h00000000, 4'hF, 0, 0, p0, p1));
    vecs.push_back(mk(1, 6'h00, 32'h00000001, 4'b1110, 0, 0, p0, p1));
    vecs.push_back(mk(0, 6'h00, 0, 0, 32'h4, 0, p0, p1));

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_awready_in_reset", 64'(awready), 64'h1);
    check("rst_bvalid_in_reset", 64'(bvalid), 64'h0);
    ap_rst_n = 1'b1;
    tick();
    check("rst_awready", 64'(awready), 64'h1);
    check("rst_arready", 64'(arready), 64'h1);
    check("rst_wready", 64'(wready), 64'h0);
    check("rst_bvalid", 64'(bvalid), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_rdata", 64'(rdata), 64'h0);
    check("rst_ap_start", 64'(ap_start), 64'h0);
    check("rst_ptr0", ptr0, 64'h0);
    check("rst_ptr1", ptr1, 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0);
      end else begin
        axi_read(vecs[i].addr, 1'b0, rd);
        check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      end
      check($sformatf("vec%0d_ap_start", i), 64'(ap_start), 64'(vecs[i].exp_start));
      check($sformatf("vec%0d_ptr0", i), ptr0, vecs[i].exp_p0);
      check($sformatf("vec%0d_ptr1", i), ptr1, vecs[i].exp_p1);
    end

    // Start, pointer write while running, done clears start, sticky clear-on-read
    axi_write(6'h00, 32'h1, 4'hF, 1'b0);
    check("start_set", 64'(ap_start), 64'h1);
    axi_write(6'h1C, 32'h5, 4'hF, 1'b0);
    p1 = 64'h00000005_AA345678;
    check("ptr1_while_running", ptr1, p1);
    check("start_kept", 64'(ap_start), 64'h1);
    ap_idle = 1'b0;
    pulse_done();
    check("start_cleared_by_done", 64'(ap_start), 64'h0);
    axi_read(6'h00, 1'b0, rd);
    check("ctrl_done_first_read", 64'(rd), 64'h2);
    axi_read(6'h00, 1'b0, rd);
    check("ctrl_done_second_read", 64'(rd), 64'h0);
    ap_idle = 1'b1;

    // ap_done on the same edge as the clearing AR handshake
    axi_read(6'h00, 1'b1, rd);
    check("ctrl_read_pre_clear", 64'(rd), 64'h4);
    axi_read(6'h00, 1'b0, rd);
    check("ctrl_done_survives_clear", 64'(rd), 64'h6);
    axi_read(6'h00, 1'b0, rd);
    check("ctrl_done_cleared", 64'(rd), 64'h4);

    // Set-write on the same edge as ap_done
    axi_write(6'h00, 32'h1, 4'h1, 1'b1);
    check("start_set_wins", 64'(ap_start), 64'h1);
    axi_read(6'h00, 1'b0, rd);
    check("ctrl_start_done_idle", 64'(rd), 64'h7);
    pulse_done();
    check("start_cleared_again", 64'(ap_start), 64'h0);
    axi_read(6'h00, 1'b0, rd);
    check("ctrl_after_second_done", 64'(rd), 64'h6);

    // Held write response: no second write accepted, reads proceed meanwhile
    check("hold_awready_idle", 64'(awready), 64'h1);
    awaddr = 6'h10; awvalid = 1'b1;
    wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    tick();
    awaddr = 6'h18; wdata = 32'h22222222;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold_bvalid_%0d", c), 64'(bvalid), 64'h1);
      check($sformatf("hold_awready_%0d", c), 64'(awready), 64'h0);
      check($sformatf("hold_wready_%0d", c), 64'(wready), 64'h0);
      tick();
    end
    p0 = 64'h0000FF01_11111111;
    check("hold_ptr0", ptr0, p0);
    axi_read(6'h10, 1'b0, rd);
    check("concurrent_read", 64'(rd), 64'h11111111);
    check("hold_bvalid_after_read", 64'(bvalid), 64'h1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
    check("release_bvalid", 64'(bvalid), 64'h0);
    check("release_awready", 64'(awready), 64'h1);
    check("release_ptr1", ptr1, p1);
    check("release_ptr0", ptr0, p0);

    // Read data held stable while rready is low
    araddr = 6'h18; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rhold_rvalid_%0d", c), 64'(rvalid), 64'h1);
      check($sformatf("rhold_rdata_%0d", c), 64'(rdata), 64'hAA345678);
      check($sformatf("rhold_arready_%0d", c), 64'(arready), 64'h0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rhold_release", 64'(rvalid), 64'h0);

`ifdef CTRL_IRQ_EN
    axi_write(6'h04, 32'h1, 4'hF, 1'b0);
    axi_write(6'h08, 32'h1, 4'hF, 1'b0);
    check("irq_idle", 64'(interrupt), 64'h0);
    pulse_done();
    tick();
    check("irq_raised", 64'(interrupt), 64'h1);
    axi_read(6'h0C, 1'b0, rd);
    check("isr_read", 64'(rd), 64'h1);
    axi_read(6'h08, 1'b0, rd);
    check("ier_read", 64'(rd), 64'h1);
    axi_write(6'h0C, 32'h1, 4'hF, 1'b0);
    tick();
    check("irq_cleared", 64'(interrupt), 64'h0);
    axi_read(6'h0C, 1'b0, rd);
    check("isr_cleared", 64'(rd), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
